// File: rtl/brfwd_pkg.sv
// Shared definitions for the ID-stage branch forwarding / hazard unit:
// forward-select encodings, FSM state encoding and the default register-address width.
package brfwd_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/brfwd_src_match.sv
// Per-source comparator: flags which pipeline stage will write this ID source register
// and picks the forwarding source (EX/MEM has priority over MEM/WB).
module brfwd_src_match
  import brfwd_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              idex_regwrite_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  output logic              idex_match_o,
  output logic              exmem_match_o,
  output logic              memwb_match_o,
  output logic [1:0]        fwd_sel_o
);

  // Register 0 is hardwired; a write to it never produces a value to forward.
  assign idex_match_o  = idex_regwrite_i  && (idex_rd_i  != '0) && (idex_rd_i  == src_i);
  assign exmem_match_o = exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i);
  assign memwb_match_o = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i);

  always_comb begin
    fwd_sel_o = FWD_RF;
    if (exmem_match_o) begin
      fwd_sel_o = FWD_EXMEM;
    end else if (memwb_match_o) begin
      fwd_sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/branch_fwd_hazard_unit.sv
// ID-stage branch operand forwarding plus stall sequencer (ALU-use 1 bubble, load-use 2).
// Optional stall-cycle performance counter enabled by defining BRFWD_PERF_EN.
module branch_fwd_hazard_unit
  import brfwd_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int NUM_SRC   = 2,
  parameter int MAX_STALL = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_branch,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic                      idex_regwrite,
  input  logic                      idex_memread,
  input  logic [REG_AW-1:0]         idex_rd,
  input  logic                      exmem_regwrite,
  input  logic                      exmem_memread,
  input  logic [REG_AW-1:0]         exmem_rd,
  input  logic                      memwb_regwrite,
  input  logic [REG_AW-1:0]         memwb_rd,
  input  logic                      pipe_hold,
  input  logic                      id_kill,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic [31:0]               perf_stall_cycles,
  output state_t                    dbg_state
);

  localparam int CNT_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  logic [NUM_SRC-1:0] m_idex;
  logic [NUM_SRC-1:0] m_exmem;
  logic [NUM_SRC-1:0] m_memwb;
  logic [1:0]         sel_raw [NUM_SRC];

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               hazard_en;
  logic [1:0]         need_all;
  logic [CNT_W-1:0]   need_sat;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    brfwd_src_match #(
      .REG_AW(REG_AW)
    ) u_match (
      .src_i            (id_src[g*REG_AW +: REG_AW]),
      .idex_regwrite_i  (idex_regwrite),
      .idex_rd_i        (idex_rd),
      .exmem_regwrite_i (exmem_regwrite),
      .exmem_rd_i       (exmem_rd),
      .memwb_regwrite_i (memwb_regwrite),
      .memwb_rd_i       (memwb_rd),
      .idex_match_o     (m_idex[g]),
      .exmem_match_o    (m_exmem[g]),
      .memwb_match_o    (m_memwb[g]),
      .fwd_sel_o        (sel_raw[g])
    );
  end

  assign hazard_en = id_branch && !id_kill && (state_q == ST_IDLE);

  // The worst source decides how many bubbles the branch needs.
  always_comb begin
    logic [1:0] src_need;
    src_need = 2'd0;
    need_all = 2'd0;
    if (hazard_en) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (m_idex[i] && idex_memread) begin
          src_need = 2'd2;
        end else if (m_idex[i]) begin
          src_need = 2'd1;
        end else if (m_exmem[i] && exmem_memread) begin
          src_need = 2'd1;
        end else begin
          src_need = 2'd0;
        end
        need_all = max_need(need_all, src_need);
      end
    end
  end

  always_comb begin
    need_sat = '0;
    if (int'(need_all) > MAX_STALL) begin
      need_sat = CNT_W'(MAX_STALL);
    end else begin
      need_sat = CNT_W'(need_all);
    end
  end

  // Reset is folded in so the stall drops the instant reset rises, not at the next edge.
  assign stall = !reset && !id_kill && ((state_q == ST_WAIT) || (need_sat != '0));

  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (stall || !id_branch || !(m_exmem[i] || m_memwb[i])) begin
        fwd_sel[2*i +: 2] = FWD_RF;
      end else begin
        fwd_sel[2*i +: 2] = sel_raw[i];
      end
    end
  end

  // Only a need above one bubble requires WAIT; a single bubble re-evaluates from IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (id_kill) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (!pipe_hold) begin
      case (state_q)
        ST_IDLE: begin
          if (need_sat > CNT_W'(1)) begin
            state_q <= ST_WAIT;
            cnt_q   <= need_sat - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign dbg_state = state_q;

`ifdef BRFWD_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (stall && !pipe_hold && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_branch_fwd_hazard_unit.sv
// Directed bench for branch_fwd_hazard_unit: table of single-cycle forwarding/hazard
// vectors followed by hand-written multi-cycle stall, hold, kill and reset sequences.
module tb_branch_fwd_hazard_unit;
  import brfwd_pkg::*;

`ifdef BRFWD_PERF_EN
  localparam logic [31:0] EXP_PERF2 = 32'd2;
`else
  localparam logic [31:0] EXP_PERF2 = 32'd0;
`endif

  logic        clk;
  logic        reset;
  logic        id_branch;
  logic [9:0]  id_src;
  logic        idex_regwrite, idex_memread;
  logic [4:0]  idex_rd;
  logic        exmem_regwrite, exmem_memread;
  logic [4:0]  exmem_rd;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic        pipe_hold;
  logic        id_kill;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [31:0] perf_stall_cycles;
  state_t      dbg_state;

  int checks;
  int errors;
  int stall_seen;

  branch_fwd_hazard_unit dut (
    .clk               (clk),
    .reset             (reset),
    .id_branch         (id_branch),
    .id_src            (id_src),
    .idex_regwrite     (idex_regwrite),
    .idex_memread      (idex_memread),
    .idex_rd           (idex_rd),
    .exmem_regwrite    (exmem_regwrite),
    .exmem_memread     (exmem_memread),
    .exmem_rd          (exmem_rd),
    .memwb_regwrite    (memwb_regwrite),
    .memwb_rd          (memwb_rd),
    .pipe_hold         (pipe_hold),
    .id_kill           (id_kill),
    .fwd_sel           (fwd_sel),
    .stall             (stall),
    .perf_stall_cycles (perf_stall_cycles),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       br;
    logic [4:0] s0;
    logic [4:0] s1;
    logic       irw;
    logic       imr;
    logic [4:0] ird;
    logic       erw;
    logic       emr;
    logic [4:0] erd;
    logic       mrw;
    logic [4:0] mrd;
    logic       kill;
    logic [3:0] exp_fwd;
    logic       exp_stall;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic br, input logic [4:0] s0, input logic [4:0] s1,
                              input logic irw, input logic imr, input logic [4:0] ird,
                              input logic erw, input logic emr, input logic [4:0] erd,
                              input logic mrw, input logic [4:0] mrd, input logic kill,
                              input logic [3:0] exp_fwd, input logic exp_stall);
    vec_t v;
    v.br = br; v.s0 = s0; v.s1 = s1;
    v.irw = irw; v.imr = imr; v.ird = ird;
    v.erw = erw; v.emr = emr; v.erd = erd;
    v.mrw = mrw; v.mrd = mrd; v.kill = kill;
    v.exp_fwd = exp_fwd; v.exp_stall = exp_stall;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    id_branch = 1'b0; id_src = '0;
    idex_regwrite = 1'b0; idex_memread = 1'b0; idex_rd = '0;
    exmem_regwrite = 1'b0; exmem_memread = 1'b0; exmem_rd = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0;
    pipe_hold = 1'b0; id_kill = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    id_branch = v.br; id_src = {v.s1, v.s0};
    idex_regwrite = v.irw; idex_memread = v.imr; idex_rd = v.ird;
    exmem_regwrite = v.erw; exmem_memread = v.emr; exmem_rd = v.erd;
    memwb_regwrite = v.mrw; memwb_rd = v.mrd;
    id_kill = v.kill; pipe_hold = 1'b0;
  endtask

  // Load in ID/EX feeding src0 of a branch: needs two bubbles.
  task automatic drive_load_use();
    clear_inputs();
    id_branch = 1'b1; id_src = {5'd0, 5'd4};
    idex_regwrite = 1'b1; idex_memread = 1'b1; idex_rd = 5'd4;
  endtask

  task automatic load_in_exmem();
    idex_regwrite = 1'b0; idex_memread = 1'b0; idex_rd = '0;
    exmem_regwrite = 1'b1; exmem_memread = 1'b1; exmem_rd = 5'd4;
  endtask

  task automatic load_in_memwb();
    exmem_regwrite = 1'b0; exmem_memread = 1'b0; exmem_rd = '0;
    memwb_regwrite = 1'b1; memwb_rd = 5'd4;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    clear_inputs();

    vecs[0]  = mk(1, 2, 3, 0, 0, 0, 1, 0, 2, 1, 3, 0, 4'b0110, 0);
    vecs[1]  = mk(1, 5, 6, 0, 0, 0, 1, 0, 5, 1, 5, 0, 4'b0010, 0);
    vecs[2]  = mk(1, 0, 6, 0, 0, 0, 1, 0, 0, 1, 0, 0, 4'b0000, 0);
    vecs[3]  = mk(0, 2, 3, 0, 0, 0, 1, 0, 2, 1, 3, 0, 4'b0000, 0);
    vecs[4]  = mk(1, 1, 7, 1, 0, 7, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    vecs[5]  = mk(1, 4, 1, 0, 0, 0, 1, 1, 4, 0, 0, 0, 4'b0000, 1);
    vecs[6]  = mk(1, 4, 1, 0, 0, 0, 1, 0, 4, 0, 0, 0, 4'b0010, 0);
    vecs[7]  = mk(1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 0, 4'b0000, 0);
    vecs[8]  = mk(1, 1, 7, 1, 0, 7, 1, 0, 1, 0, 0, 1, 4'b0010, 0);
    vecs[9]  = mk(1, 1, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    vecs[10] = mk(1, 9, 9, 0, 0, 0, 0, 0, 0, 1, 9, 0, 4'b0101, 0);
    vecs[11] = mk(1, 2, 8, 0, 0, 0, 0, 0, 2, 1, 2, 0, 4'b0001, 0);
    vecs[12] = mk(1, 8, 3, 1, 0, 3, 1, 0, 8, 0, 0, 0, 4'b0000, 1);

    do_reset();
    @(negedge clk);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_perf", perf_stall_cycles, 32'd0);
    check("reset_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    check("reset_fwd", {28'd0, fwd_sel}, 32'd0);
    next_cycle();

    for (int i = 0; i < 13; i++) begin
      apply_vec(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d_fwd", i), {28'd0, fwd_sel}, {28'd0, vecs[i].exp_fwd});
      check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    check("table_end_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});

    // load-use: two bubbles, then forward from MEM/WB
    do_reset();
    drive_load_use();
    @(negedge clk);
    check("lu_stall0", {31'd0, stall}, 32'd1);
    check("lu_fwd0", {28'd0, fwd_sel}, 32'd0);
    next_cycle();
    load_in_exmem();
    @(negedge clk);
    check("lu_stall1", {31'd0, stall}, 32'd1);
    check("lu_state1", {31'd0, dbg_state}, {31'd0, ST_WAIT});
    next_cycle();
    load_in_memwb();
    @(negedge clk);
    check("lu_stall2", {31'd0, stall}, 32'd0);
    check("lu_state2", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    check("lu_fwd2", {28'd0, fwd_sel}, 32'b0001);
    next_cycle();
    check("lu_perf", perf_stall_cycles, EXP_PERF2);

    // load-use with a 3-cycle freeze in WAIT
    do_reset();
    stall_seen = 0;
    drive_load_use();
    @(negedge clk);
    if (stall) stall_seen++;
    next_cycle();
    load_in_exmem();
    pipe_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (stall) stall_seen++;
      check($sformatf("hold%0d_state", k), {31'd0, dbg_state}, {31'd0, ST_WAIT});
      next_cycle();
    end
    pipe_hold = 1'b0;
    @(negedge clk);
    if (stall) stall_seen++;
    next_cycle();
    load_in_memwb();
    @(negedge clk);
    if (stall) stall_seen++;
    check("hold_stall_cycles", stall_seen, 32'd5);
    check("hold_fwd_after", {28'd0, fwd_sel}, 32'b0001);
    next_cycle();
    check("hold_perf", perf_stall_cycles, EXP_PERF2);

    // kill in WAIT beats a simultaneous hold
    do_reset();
    drive_load_use();
    next_cycle();
    load_in_exmem();
    pipe_hold = 1'b1;
    id_kill = 1'b1;
    #1;
    check("kill_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    check("kill_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    clear_inputs();
    @(negedge clk);
    check("kill_stall_after", {31'd0, stall}, 32'd0);
    next_cycle();

    // asynchronous reset while held in WAIT
    do_reset();
    drive_load_use();
    next_cycle();
    load_in_exmem();
    pipe_hold = 1'b1;
    @(negedge clk);
    check("rst_pre_stall", {31'd0, stall}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_stall", {31'd0, stall}, 32'd0);
    check("rst_async_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    clear_inputs();
    #1;
    reset = 1'b0;
    next_cycle();

    // ALU producer: one bubble, then forward from EX/MEM on src1
    do_reset();
    id_branch = 1'b1; id_src = {5'd7, 5'd1};
    idex_regwrite = 1'b1; idex_rd = 5'd7;
    @(negedge clk);
    check("alu_stall0", {31'd0, stall}, 32'd1);
    next_cycle();
    check("alu_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    idex_regwrite = 1'b0; idex_rd = '0;
    exmem_regwrite = 1'b1; exmem_rd = 5'd7;
    @(negedge clk);
    check("alu_stall1", {31'd0, stall}, 32'd0);
    check("alu_fwd1", {28'd0, fwd_sel}, 32'b1000);
    next_cycle();
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
